key_router: RTL and testbench

Keyboard event router between the ASCII key decoder and its two consumers: the menu controller and the game logic. It filters auto-repeat with a same-key hold-off and buffers accepted key codes in a small FIFO. Each code is then dispatched to exactly one consumer over a valid/ready handshake. The router replaces per-consumer key polling, so every keypress is consumed once and in order.

---
 rtl/key_router.sv | 147 ++++++++++++++
 tb/tb_key_router.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_router.sv
// key_router: hold-off filter, key FIFO and menu/game dispatch with valid/ready handshakes.
// Optional KEY_ROUTER_DROP_CNT_EN adds a saturating drop_count output.
module key_router #(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLDOFF    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    key_in,
    input  logic                          key_strobe,
    input  logic                          menu_open,
    output logic [7:0]                    menu_key,
    output logic                          menu_key_valid,
    input  logic                          menu_key_ready,
    output logic [7:0]                    game_key,
    output logic                          game_key_valid,
    input  logic                          game_key_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
`ifdef KEY_ROUTER_DROP_CNT_EN
    output logic [7:0]                    drop_count,
`endif
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int HW = $clog2(HOLDOFF + 1);

    localparam logic [7:0] KEY_ESC   = 8'h1b;
    localparam logic [7:0] KEY_ENTER = 8'h0d;

    typedef enum logic [1:0] {IDLE, WAIT_MENU, WAIT_GAME} state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      last_code;
    logic [HW-1:0]   holdoff_cnt;

    logic            candidate;
    logic            discard;
    logic            accept;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            drop;
    logic [7:0]      head;
    logic            to_menu;

    always_comb begin
        candidate = key_strobe && (key_in != 8'h00);
        discard   = candidate && (key_in == last_code) && (holdoff_cnt != '0);
        accept    = candidate && !discard;
        full      = (fifo_level == LW'(FIFO_DEPTH));
        pop       = (state == IDLE) && (fifo_level != '0);
        // A pop in the same cycle frees the slot the push needs.
        push_ok   = accept && (!full || pop);
        drop      = accept && full && !pop;
        head      = mem[rd_ptr];
        to_menu   = (head == KEY_ESC) || menu_open || (head == KEY_ENTER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_code   <= 8'h00;
            holdoff_cnt <= '0;
        end else if (accept) begin
            last_code   <= key_in;
            holdoff_cnt <= HW'(HOLDOFF);
        end else if (holdoff_cnt != '0) begin
            holdoff_cnt <= holdoff_cnt - HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= key_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)
                fifo_level <= fifo_level + LW'(1);
            else if (pop && !push_ok)
                fifo_level <= fifo_level - LW'(1);
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef KEY_ROUTER_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_count <= 8'h00;
        else if (drop && drop_count != 8'hff)
            drop_count <= drop_count + 8'h01;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            menu_key       <= 8'h00;
            menu_key_valid <= 1'b0;
            game_key       <= 8'h00;
            game_key_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        if (to_menu) begin
                            menu_key       <= head;
                            menu_key_valid <= 1'b1;
                            state          <= WAIT_MENU;
                        end else begin
                            game_key       <= head;
                            game_key_valid <= 1'b1;
                            state          <= WAIT_GAME;
                        end
                    end
                end
                WAIT_MENU: begin
                    if (menu_key_ready) begin
                        menu_key       <= 8'h00;
                        menu_key_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                WAIT_GAME: begin
                    if (game_key_ready) begin
                        game_key       <= 8'h00;
                        game_key_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_router.sv
// tb_key_router: directed scenarios plus randomized traffic checked
// against a queue-based transaction model of key_router.
module tb_key_router;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] key_in = 8'h00;
    logic       key_strobe = 1'b0;
    logic       menu_open = 1'b0;
    logic [7:0] menu_key;
    logic       menu_key_valid;
    logic       menu_key_ready = 1'b0;
    logic [7:0] game_key;
    logic       game_key_valid;
    logic       game_key_ready = 1'b0;
    logic [2:0] fifo_level;
    logic       overflow;
`ifdef KEY_ROUTER_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    int tests = 0;
    int fails = 0;

    key_router #(.FIFO_DEPTH(DEPTH), .HOLDOFF(HOLD)) dut (
        .clk            (clk),
        .rst            (rst),
        .key_in         (key_in),
        .key_strobe     (key_strobe),
        .menu_open      (menu_open),
        .menu_key       (menu_key),
        .menu_key_valid (menu_key_valid),
        .menu_key_ready (menu_key_ready),
        .game_key       (game_key),
        .game_key_valid (game_key_valid),
        .game_key_ready (game_key_ready),
        .fifo_level     (fifo_level),
`ifdef KEY_ROUTER_DROP_CNT_EN
        .drop_count     (drop_count),
`endif
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: queue of pending codes plus one held output.
    logic [7:0] mq[$];
    bit         m_hold;
    bit         m_menu;
    logic [7:0] m_key;
    bit         m_ovf;
    int         m_drops;
    logic [7:0] m_last;
    int         m_last_cyc;
    int         m_cyc;

    task automatic model_reset();
        mq.delete();
        m_hold = 0; m_menu = 0; m_key = 8'h00;
        m_ovf = 0; m_drops = 0;
        m_last = 8'h00; m_last_cyc = -1000; m_cyc = 0;
    endtask

    task automatic model_step();
        logic [7:0] c;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_hold) begin
            if (m_menu ? menu_key_ready : game_key_ready) m_hold = 0;
        end else if (mq.size() > 0) begin
            c = mq.pop_front();
            m_key = c;
            m_menu = (c == 8'h1b) || menu_open || (c == 8'h0d);
            m_hold = 1;
        end
        if (key_strobe && key_in != 8'h00 &&
            !(key_in == m_last && (m_cyc - m_last_cyc) < HOLD + 1)) begin
            m_last = key_in;
            m_last_cyc = m_cyc;
            if (mq.size() < DEPTH) mq.push_back(key_in);
            else begin m_ovf = 1; m_drops++; end
        end
        m_cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        key_strobe = 0; key_in = 8'h00;
        rst = 1;
        #1 model_reset();
        @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic strobe(input logic [7:0] k);
        key_in = k; key_strobe = 1;
        tick();
        key_in = 8'h00; key_strobe = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        #1;
        tests++;
        if ({menu_key_valid, game_key_valid, menu_key, game_key, overflow} !== 19'd0) begin
            fails++;
            $display("FAIL reset_outputs got mv=%b gv=%b mk=%h gk=%h ovf=%b exp all 0",
                     menu_key_valid, game_key_valid, menu_key, game_key, overflow);
        end
        tests++;
        if (fifo_level !== 3'd0) begin
            fails++; $display("FAIL reset_level got=%0d exp=0", fifo_level);
        end
`ifdef KEY_ROUTER_DROP_CNT_EN
        tests++;
        if (drop_count !== 8'h00) begin
            fails++; $display("FAIL reset_drop_count got=%h exp=00", drop_count);
        end
`endif
        do_reset();
    endtask

    task automatic test_single_key();
        do_reset();
        menu_open = 0; menu_key_ready = 1; game_key_ready = 1;
        strobe(8'h77);
        tests++;
        if (fifo_level !== 3'd1 || game_key_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_lat1 got lvl=%0d gv=%b exp lvl=1 gv=0", fifo_level, game_key_valid);
        end
        tick();
        tests++;
        if (game_key_valid !== 1'b1 || game_key !== 8'h77 || fifo_level !== 3'd0) begin
            fails++;
            $display("FAIL single_lat2 got gv=%b gk=%h lvl=%0d exp gv=1 gk=77 lvl=0",
                     game_key_valid, game_key, fifo_level);
        end
        tests++;
        if (menu_key_valid !== 1'b0 || menu_key !== 8'h00) begin
            fails++;
            $display("FAIL single_menu_idle got mv=%b mk=%h exp 0 00", menu_key_valid, menu_key);
        end
        tick();
        tests++;
        if (game_key_valid !== 1'b0 || game_key !== 8'h00) begin
            fails++;
            $display("FAIL single_one_cycle got gv=%b gk=%h exp 0 00", game_key_valid, game_key);
        end
    endtask

    task automatic test_routing();
        logic [7:0] codes [4] = '{8'h1b, 8'h31, 8'h0d, 8'h61};
        bit         mo    [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        bit         to_m  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        menu_key_ready = 1; game_key_ready = 1;
        for (int i = 0; i < 4; i++) begin
            do_reset();
            menu_open = mo[i];
            strobe(codes[i]);
            tick();
            tests++;
            if (menu_key_valid !== to_m[i] || game_key_valid !== !to_m[i] ||
                (to_m[i] ? menu_key : game_key) !== codes[i]) begin
                fails++;
                $display("FAIL route_%0d got mv=%b gv=%b mk=%h gk=%h exp menu=%b key=%h",
                         i, menu_key_valid, game_key_valid, menu_key, game_key, to_m[i], codes[i]);
            end
            tick();
        end
        menu_open = 0;
    endtask

    task automatic test_holdoff();
        logic [7:0] got[$];
        do_reset();
        menu_open = 0; game_key_ready = 1; menu_key_ready = 1;
        for (int c = 0; c < 14; c++) begin
            key_strobe = (c == 0 || c == 2 || c == 6);
            key_in = key_strobe ? 8'h61 : 8'h00;
            tick();
            if (game_key_valid) got.push_back(game_key);
        end
        key_strobe = 0; key_in = 8'h00;
        tests++;
        if (got.size() != 2) begin
            fails++; $display("FAIL holdoff_repeat got=%0d deliveries exp=2", got.size());
        end
        got.delete();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            key_strobe = (c < 2);
            key_in = (c == 0) ? 8'h61 : (c == 1) ? 8'h62 : 8'h00;
            tick();
            if (game_key_valid) got.push_back(game_key);
        end
        key_strobe = 0; key_in = 8'h00;
        tests++;
        if (got.size() != 2 || got[0] !== 8'h61 || got[1] !== 8'h62) begin
            fails++;
            $display("FAIL holdoff_diff got n=%0d first=%h second=%h exp n=2 61 62",
                     got.size(), got.size() > 0 ? got[0] : 8'h00, got.size() > 1 ? got[1] : 8'h00);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] got[$];
        do_reset();
        menu_open = 0; game_key_ready = 0; menu_key_ready = 0;
        for (int i = 0; i < 6; i++) strobe(8'h41 + 8'(i));
        tests++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_fill got lvl=%0d ovf=%b exp lvl=4 ovf=1", fifo_level, overflow);
        end
        tests++;
        if (game_key_valid !== 1'b1 || game_key !== 8'h41) begin
            fails++;
            $display("FAIL ovf_head got gv=%b gk=%h exp 1 41", game_key_valid, game_key);
        end
`ifdef KEY_ROUTER_DROP_CNT_EN
        tests++;
        if (drop_count !== 8'h01) begin
            fails++; $display("FAIL ovf_drop_count got=%h exp=01", drop_count);
        end
`endif
        game_key_ready = 1;
        for (int i = 0; i < 12; i++) begin
            if (game_key_valid) got.push_back(game_key);
            tick();
        end
        tests++;
        if (got.size() != 5) begin
            fails++; $display("FAIL ovf_drain_count got=%0d exp=5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (got[i] !== 8'h41 + 8'(i)) begin
                    fails++; $display("FAIL ovf_order_%0d got=%h exp=%h", i, got[i], 8'h41 + 8'(i));
                end
            end
        end
        tests++;
        if (overflow !== 1'b1) begin
            fails++; $display("FAIL ovf_sticky got=%b exp=1", overflow);
        end
    endtask

    task automatic test_stability();
        do_reset();
        menu_open = 0; game_key_ready = 0; menu_key_ready = 1;
        strobe(8'h61);
        tick();
        for (int i = 0; i < 6; i++) begin
            menu_open = (i % 2 == 0);
            tick();
            tests++;
            if (game_key_valid !== 1'b1 || game_key !== 8'h61 || menu_key_valid !== 1'b0) begin
                fails++;
                $display("FAIL stable_%0d got gv=%b gk=%h mv=%b exp 1 61 0",
                         i, game_key_valid, game_key, menu_key_valid);
            end
        end
        game_key_ready = 1;
        tick();
        tests++;
        if (game_key_valid !== 1'b0 || menu_key_valid !== 1'b0 || fifo_level !== 3'd0) begin
            fails++;
            $display("FAIL stable_done got gv=%b mv=%b lvl=%0d exp 0 0 0",
                     game_key_valid, menu_key_valid, fifo_level);
        end
        menu_open = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        menu_open = 1; menu_key_ready = 0; game_key_ready = 1;
        strobe(8'h31);
        strobe(8'h32);
        strobe(8'h33);
        tests++;
        if (menu_key_valid !== 1'b1 || menu_key !== 8'h31 || fifo_level !== 3'd2) begin
            fails++;
            $display("FAIL arst_pre got mv=%b mk=%h lvl=%0d exp 1 31 2",
                     menu_key_valid, menu_key, fifo_level);
        end
        #2 rst = 1;
        #1;
        model_reset();
        tests++;
        if ({menu_key_valid, game_key_valid, menu_key, game_key, overflow} !== 19'd0 ||
            fifo_level !== 3'd0) begin
            fails++;
            $display("FAIL arst_now got mv=%b gv=%b mk=%h gk=%h lvl=%0d exp all 0",
                     menu_key_valid, game_key_valid, menu_key, game_key, fifo_level);
        end
        @(negedge clk);
        rst = 0;
        menu_open = 0; menu_key_ready = 1;
        strobe(8'h34);
        tick();
        tests++;
        if (game_key_valid !== 1'b1 || game_key !== 8'h34 || menu_key_valid !== 1'b0) begin
            fails++;
            $display("FAIL arst_after got gv=%b gk=%h mv=%b exp 1 34 0",
                     game_key_valid, game_key, menu_key_valid);
        end
    endtask

    task automatic test_random();
        logic [7:0] keys [7] = '{8'h61, 8'h61, 8'h62, 8'h1b, 8'h0d, 8'h31, 8'h00};
        logic [7:0] e_mk, e_gk;
        bit e_mv, e_gv;
        int bad;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            key_strobe = ($urandom_range(0, 1) == 1);
            key_in = keys[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) menu_open = ~menu_open;
            menu_key_ready = ($urandom_range(0, 9) < 6);
            game_key_ready = ($urandom_range(0, 9) < 6);
            tick();
            e_mv = m_hold && m_menu;
            e_gv = m_hold && !m_menu;
            e_mk = e_mv ? m_key : 8'h00;
            e_gk = e_gv ? m_key : 8'h00;
            bad = 0;
            if (menu_key_valid !== e_mv || menu_key !== e_mk) bad = 1;
            if (game_key_valid !== e_gv || game_key !== e_gk) bad = 1;
            if (fifo_level !== 3'(mq.size()) || overflow !== m_ovf) bad = 1;
`ifdef KEY_ROUTER_DROP_CNT_EN
            if (drop_count !== 8'(m_drops > 255 ? 255 : m_drops)) bad = 1;
`endif
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL rand_cyc%0d got mv=%b mk=%h gv=%b gk=%h lvl=%0d ovf=%b exp mv=%b mk=%h gv=%b gk=%h lvl=%0d ovf=%b",
                         c, menu_key_valid, menu_key, game_key_valid, game_key, fifo_level, overflow,
                         e_mv, e_mk, e_gv, e_gk, mq.size(), m_ovf);
            end
        end
        key_strobe = 0; key_in = 8'h00;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_key();
        test_routing();
        test_holdoff();
        test_overflow();
        test_stability();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
